mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM stage of the 5-stage pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its Mem_* outputs.
- Issues load/store transactions to the data-memory bus over a req/ack handshake and stalls upstream stages while a transaction is outstanding.
- Registers results into the MEM/WB boundary (Wb_* outputs) for writeback.

Parameters:
- DW, 32, data width of register and memory data
- AW, 32, memory address width; taken from the low AW bits of Mem_Alu_R
- TIMEOUT_CYCLES, 15, WAIT-state cycles before abort; used only with MEM_TIMEOUT_EN

Ports:
- clk  in  1  clock; all state changes on the rising edge
- clr  in  1  synchronous reset, active-high
- Mem_Wreg  in  1  instruction writes the register file
- Mem_Reg2reg  in  1  instruction is a load; writeback selects memory data
- Mem_Wmem  in  1  instruction is a store
- Mem_Alu_R  in  DW  ALU result; memory address for loads and stores
- Mem_D2  in  DW  store data
- Mem_Rd  in  5  destination register
- dm_req  out  1  memory request, registered
- dm_we  out  1  1 = write, 0 = read, registered
- dm_addr  out  AW  request address, registered
- dm_wdata  out  DW  store data, registered
- dm_ack  in  1  memory acknowledge, one-cycle pulse
- dm_rdata  in  DW  read data, valid when dm_ack=1
- stall  out  1  combinational; drives en=0 on the PC, IF/ID, ID/EX and EX/MEM registers
- mem_err  out  1  timeout pulse, registered
- Wb_Wreg  out  1  MEM/WB register-write flag
- Wb_Reg2reg  out  1  MEM/WB load flag
- Wb_Rd  out  5  MEM/WB destination register
- Wb_Alu_R  out  DW  MEM/WB ALU result
- Wb_Mem_R  out  DW  MEM/WB load data

Behaviour:
- Reset: clk and a synchronous, active-high clr. When clr=1 at a rising edge:
  - state goes to IDLE
  - all outputs are cleared: dm_req, dm_we, dm_addr, dm_wdata, mem_err, and all Wb_* outputs become 0
  - the timeout counter clears
  - clr has priority over every other event.
- mem_op = Mem_Wmem | Mem_Reg2reg. If both are set, the instruction is treated as a store and Wb_Mem_R is loaded with 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If mem_op=1: stall=1. Next state is WAIT. On the same edge dm_req<=1, dm_we<=Mem_Wmem, dm_addr<=Mem_Alu_R[AW-1:0], dm_wdata<=Mem_D2.
  - If mem_op=0: stall=0 and the state stays IDLE.
  - dm_ack seen in IDLE is ignored.
- WAIT:
  - stall=1. dm_req, dm_we, dm_addr and dm_wdata are held stable until ack.
  - On dm_ack=1: dm_req<=0, internal rdata register<=dm_rdata (loads only), next state is DONE.
- DONE:
  - stall=0 and the state returns unconditionally to IDLE.
  - The EX/MEM inputs still hold the same instruction during DONE, so it is never re-issued.
- Minimum memory-op cost: 2 stall cycles (IDLE detect, WAIT with ack in the first WAIT cycle). Non-memory ops: 0 stall cycles.
- MEM/WB register on each edge without clr:
  - stall=0: Wb_Wreg<=Mem_Wreg, Wb_Reg2reg<=Mem_Reg2reg, Wb_Rd<=Mem_Rd, Wb_Alu_R<=Mem_Alu_R. Wb_Mem_R<=rdata register for a load; otherwise it holds its value.
  - stall=1: a bubble is inserted. Wb_Wreg<=0, Wb_Reg2reg<=0, Wb_Rd<=0. Wb_Alu_R and Wb_Mem_R hold.
- Writeback latency: one cycle after the cycle in which stall=0.
- Reset mid-transaction: dm_req drops on the clr edge. The memory bus must tolerate an abandoned request, and any dm_ack after reset is ignored in IDLE.
- Back-to-back memory ops: the sequence DONE -> IDLE -> WAIT repeats. Each op costs 3 cycles minimum in the MEM stage.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With MEM_TIMEOUT_EN defined:
  - A counter increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: dm_req<=0, rdata register<=0, mem_err<=1 for exactly one cycle, next state is DONE.
  - The instruction then retires normally, with load data = 0.
  - The counter clears on leaving WAIT.
- Without MEM_TIMEOUT_EN: WAIT is held indefinitely, mem_err is tied to 0, and no counter logic exists.

Test Plan:
- Reset: clr=1 for 2 cycles with Mem_Wmem=1 held -> dm_req=0, stall=0, all Wb_*=0 during reset; dm_req=1 one cycle after clr falls.
- ALU op Mem_Wreg=1, Mem_Rd=5, Mem_Alu_R=0x1234 -> stall never asserted; one cycle later Wb_Wreg=1, Wb_Rd=5, Wb_Alu_R=0x1234.
- Load Mem_Reg2reg=1, Mem_Alu_R=0x40, dm_ack after 3 WAIT cycles with dm_rdata=0xDEADBEEF:
  - stall=1 for 4 cycles
  - dm_addr=0x40, dm_we=0
  - then Wb_Mem_R=0xDEADBEEF, Wb_Reg2reg=1
  - bubbles (Wb_Wreg=0) during the stall.
- Store Mem_Wmem=1, Mem_Alu_R=0x80, Mem_D2=0xA5A5A5A5, ack in the first WAIT cycle -> dm_we=1, dm_wdata=0xA5A5A5A5, exactly 2 stall cycles, no re-issue in DONE.
- clr asserted in the 2nd WAIT cycle of a load -> dm_req=0 next cycle, state IDLE; a late dm_ack is ignored and Wb_* stay 0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_err one-cycle pulse after 4 WAIT cycles, dm_req=0, load retires with Wb_Mem_R=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM stage of the 5-stage pipeline.
// Issues loads/stores on a req/ack data-memory bus, stalls the upstream
// stages while a transaction is outstanding, and registers the MEM/WB
// boundary for writeback.
// Optional feature: define MEM_TIMEOUT_EN to abort a WAIT that sees no
// dm_ack within TIMEOUT_CYCLES cycles (mem_err pulse, load data forced to 0).
module mem_access_ctrl #(
    parameter int DW             = 32,
    parameter int AW             = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          Mem_Wreg,
    input  logic          Mem_Reg2reg,
    input  logic          Mem_Wmem,
    input  logic [DW-1:0] Mem_Alu_R,
    input  logic [DW-1:0] Mem_D2,
    input  logic [4:0]    Mem_Rd,
    output logic          dm_req,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic          dm_ack,
    input  logic [DW-1:0] dm_rdata,
    output logic          stall,
    output logic          mem_err,
    output logic          Wb_Wreg,
    output logic          Wb_Reg2reg,
    output logic [4:0]    Wb_Rd,
    output logic [DW-1:0] Wb_Alu_R,
    output logic [DW-1:0] Wb_Mem_R
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_rdata;
    logic          w_mem_op;

    assign w_mem_op = Mem_Wmem | Mem_Reg2reg;

    // Hold upstream while a memory op is detected or outstanding; never during reset.
    assign stall = ~clr & ((r_state == S_WAIT) | ((r_state == S_IDLE) & w_mem_op));

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_tcnt;

    // Transaction FSM with bus outputs registered; aborts WAIT after TIMEOUT_CYCLES.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= S_IDLE;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            mem_err  <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            mem_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        r_state  <= S_WAIT;
                        dm_req   <= 1'b1;
                        dm_we    <= Mem_Wmem;
                        dm_addr  <= Mem_Alu_R[AW-1:0];
                        dm_wdata <= Mem_D2;
                    end
                end
                S_WAIT: begin
                    if (dm_ack) begin
                        dm_req  <= 1'b0;
                        r_tcnt  <= '0;
                        r_state <= S_DONE;
                        if (!dm_we) begin
                            r_rdata <= dm_rdata;
                        end
                    end else if (r_tcnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        dm_req  <= 1'b0;
                        r_rdata <= '0;
                        mem_err <= 1'b1;
                        r_tcnt  <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
    assign mem_err = 1'b0;

    // Transaction FSM with bus outputs registered; WAIT lasts until dm_ack.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= S_IDLE;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        r_state  <= S_WAIT;
                        dm_req   <= 1'b1;
                        dm_we    <= Mem_Wmem;
                        dm_addr  <= Mem_Alu_R[AW-1:0];
                        dm_wdata <= Mem_D2;
                    end
                end
                S_WAIT: begin
                    if (dm_ack) begin
                        dm_req  <= 1'b0;
                        r_state <= S_DONE;
                        if (!dm_we) begin
                            r_rdata <= dm_rdata;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
`endif

    // MEM/WB boundary: pass the instruction through when not stalled, else insert a bubble.
    always_ff @(posedge clk) begin
        if (clr) begin
            Wb_Wreg    <= 1'b0;
            Wb_Reg2reg <= 1'b0;
            Wb_Rd      <= '0;
            Wb_Alu_R   <= '0;
            Wb_Mem_R   <= '0;
        end else if (!stall) begin
            Wb_Wreg    <= Mem_Wreg;
            Wb_Reg2reg <= Mem_Reg2reg;
            Wb_Rd      <= Mem_Rd;
            Wb_Alu_R   <= Mem_Alu_R;
            if (Mem_Reg2reg) begin
                // A load flagged as a store as well retires as a store: no load data.
                Wb_Mem_R <= Mem_Wmem ? '0 : r_rdata;
            end
        end else begin
            Wb_Wreg    <= 1'b0;
            Wb_Reg2reg <= 1'b0;
            Wb_Rd      <= '0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: vector table, hand-written reset and
// abandoned-transaction sequences, and randomized ops against a reference
// model of the MEM stage's retire rules.
module tb_mem_access_ctrl;

    logic        clk;
    logic        clr;
    logic        Mem_Wreg, Mem_Reg2reg, Mem_Wmem;
    logic [31:0] Mem_Alu_R, Mem_D2;
    logic [4:0]  Mem_Rd;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        stall, mem_err;
    logic        Wb_Wreg, Wb_Reg2reg;
    logic [4:0]  Wb_Rd;
    logic [31:0] Wb_Alu_R, Wb_Mem_R;

    int total = 0;
    int bad   = 0;

    mem_access_ctrl #(.DW(32), .AW(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .clr(clr),
        .Mem_Wreg(Mem_Wreg), .Mem_Reg2reg(Mem_Reg2reg), .Mem_Wmem(Mem_Wmem),
        .Mem_Alu_R(Mem_Alu_R), .Mem_D2(Mem_D2), .Mem_Rd(Mem_Rd),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall(stall), .mem_err(mem_err),
        .Wb_Wreg(Wb_Wreg), .Wb_Reg2reg(Wb_Reg2reg), .Wb_Rd(Wb_Rd),
        .Wb_Alu_R(Wb_Alu_R), .Wb_Mem_R(Wb_Mem_R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wreg;
        logic        r2r;
        logic        wmem;
        logic [31:0] alu;
        logic [31:0] d2;
        logic [4:0]  rd;
        int          dly;       // ack arrives in this WAIT cycle (1 = first)
        logic [31:0] rdata;
        int          exp_stall;
        logic        exp_we;
        logic [31:0] exp_memr;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present one instruction, act as memory, then check the retired MEM/WB values.
    task automatic run_op(input vec_t v);
        int nst;
        int nw;
        Mem_Wreg    = v.wreg;
        Mem_Reg2reg = v.r2r;
        Mem_Wmem    = v.wmem;
        Mem_Alu_R   = v.alu;
        Mem_D2      = v.d2;
        Mem_Rd      = v.rd;
        dm_ack      = 1'b0;
        if (!(v.wmem | v.r2r)) begin
            dm_ack   = 1'($urandom_range(0, 1));
            dm_rdata = $urandom;
        end
        nst = 0;
        nw  = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!stall) break;
            nst++;
            if (dm_req) begin
                nw++;
                if (nw == 1) begin
                    chk("req_we", dm_we, v.exp_we);
                    chk("req_addr", dm_addr, v.alu);
                    chk("req_wdata", dm_wdata, v.d2);
                end
                if (nw == v.dly) begin
                    dm_ack   = 1'b1;
                    dm_rdata = v.rdata;
                end
            end
            @(posedge clk);
            #1;
            dm_ack   = 1'b0;
            dm_rdata = $urandom;
            chk("bubble_wreg", Wb_Wreg, 1'b0);
        end
        chk("stall_cycles", nst, v.exp_stall);
        chk("req_low_unstalled", dm_req, 1'b0);
        @(posedge clk);
        #1;
        dm_ack = 1'b0;
        chk("wb_wreg", Wb_Wreg, v.wreg);
        chk("wb_reg2reg", Wb_Reg2reg, v.r2r);
        chk("wb_rd", Wb_Rd, v.rd);
        chk("wb_alu", Wb_Alu_R, v.alu);
        chk("wb_memr", Wb_Mem_R, v.exp_memr);
        chk("no_reissue", dm_req, 1'b0);
        chk("mem_err_low", mem_err, 1'b0);
    endtask

    vec_t tbl[7];
    vec_t rv;
    logic [31:0] model_memr;

    initial begin
        //              wreg r2r wmem alu           d2            rd  dly rdata         stall we   memr
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0,        5'd5,  0, 32'h0,        0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0,        5'd7,  3, 32'hDEAD_BEEF, 4, 1'b0, 32'hDEAD_BEEF};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 5'd0,  1, 32'h0,        2, 1'b1, 32'hDEAD_BEEF};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 32'hCAFE_0000, 32'h0,        5'd31, 0, 32'h0,        0, 1'b0, 32'hDEAD_BEEF};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        5'd12, 1, 32'h0123_4567, 2, 1'b0, 32'h0123_4567};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h55AA_55AA, 5'd3,  2, 32'h9999_9999, 3, 1'b1, 32'h0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  0, 32'h0,        0, 1'b0, 32'h0};

        // Reset held for two cycles with a store pending at the inputs.
        clr = 1'b1; dm_ack = 1'b0; dm_rdata = '0;
        Mem_Wreg = 1'b0; Mem_Reg2reg = 1'b0; Mem_Wmem = 1'b1;
        Mem_Alu_R = 32'h10; Mem_D2 = 32'h33; Mem_Rd = 5'd0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_req", dm_req, 1'b0);
            chk("rst_stall", stall, 1'b0);
            chk("rst_wb_wreg", Wb_Wreg, 1'b0);
            chk("rst_wb_r2r", Wb_Reg2reg, 1'b0);
            chk("rst_wb_rd", Wb_Rd, 5'd0);
            chk("rst_wb_alu", Wb_Alu_R, 32'h0);
            chk("rst_wb_memr", Wb_Mem_R, 32'h0);
            chk("rst_mem_err", mem_err, 1'b0);
        end
        clr = 1'b0;
        #1;
        chk("post_rst_stall", stall, 1'b1);
        @(posedge clk);
        #1;
        chk("post_rst_req", dm_req, 1'b1);
        chk("post_rst_addr", dm_addr, 32'h10);
        chk("post_rst_we", dm_we, 1'b1);
        Mem_Wmem = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;

        for (int i = 0; i < 7; i++) run_op(tbl[i]);

        // Reset in the 2nd WAIT cycle of a load; a late ack must be ignored.
        Mem_Wreg = 1'b1; Mem_Reg2reg = 1'b1; Mem_Wmem = 1'b0;
        Mem_Alu_R = 32'h200; Mem_D2 = 32'h0; Mem_Rd = 5'd9;
        @(posedge clk);
        #1;
        chk("mr_issue", dm_req, 1'b1);
        @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        chk("mr_stall_in_clr", stall, 1'b0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        Mem_Wreg = 1'b0; Mem_Reg2reg = 1'b0; Mem_Rd = 5'd0; Mem_Alu_R = 32'h0;
        dm_ack = 1'b1; dm_rdata = 32'h77;
        chk("mr_req_drop", dm_req, 1'b0);
        chk("mr_wb_wreg", Wb_Wreg, 1'b0);
        chk("mr_wb_r2r", Wb_Reg2reg, 1'b0);
        chk("mr_wb_memr", Wb_Mem_R, 32'h0);
        #1;
        chk("mr_late_ack_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        dm_ack = 1'b0;
        chk("mr_late_ack_req", dm_req, 1'b0);
        chk("mr_late_wb_memr", Wb_Mem_R, 32'h0);
        chk("mr_late_wb_r2r", Wb_Reg2reg, 1'b0);

`ifdef MEM_TIMEOUT_EN
        // Load that is never acknowledged: abort after 4 WAIT cycles.
        Mem_Wreg = 1'b1; Mem_Reg2reg = 1'b1; Mem_Wmem = 1'b0;
        Mem_Alu_R = 32'h300; Mem_Rd = 5'd4;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk("to_req_held", dm_req, 1'b1);
            chk("to_err_low", mem_err, 1'b0);
        end
        @(posedge clk);
        #1;
        chk("to_err_pulse", mem_err, 1'b1);
        chk("to_req_drop", dm_req, 1'b0);
        chk("to_stall_done", stall, 1'b0);
        @(posedge clk);
        #1;
        Mem_Wreg = 1'b0; Mem_Reg2reg = 1'b0; Mem_Rd = 5'd0;
        chk("to_err_one_cycle", mem_err, 1'b0);
        chk("to_wb_memr", Wb_Mem_R, 32'h0);
        chk("to_wb_r2r", Wb_Reg2reg, 1'b1);
`endif

        // Randomized ops checked against the retire-rule model.
        model_memr = 32'h0;
        for (int n = 0; n < 200; n++) begin
            rv.wreg  = 1'($urandom_range(0, 1));
            rv.r2r   = 1'($urandom_range(0, 1));
            rv.wmem  = ($urandom_range(0, 3) == 0);
            rv.alu   = $urandom;
            rv.d2    = $urandom;
            rv.rd    = 5'($urandom_range(0, 31));
            rv.dly   = $urandom_range(1, 4);
            rv.rdata = $urandom;
            rv.exp_we    = rv.wmem;
            rv.exp_stall = (rv.wmem | rv.r2r) ? 1 + rv.dly : 0;
            if (rv.r2r) model_memr = rv.wmem ? 32'h0 : rv.rdata;
            rv.exp_memr  = model_memr;
            run_op(rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
